// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - keypad entry sequencer for the 4-bit calculator (optional KEY_HOLDOFF_EN key lockout)
module calc_entry_fsm #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int HOLDOFF_CYCLES = 1_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_code,
    output logic [1:0] o_state,
    output logic [3:0] o_v1,
    output logic [3:0] o_op,
    output logic [3:0] o_v2,
    output logic       o_calc_go,
    output logic       o_err,
    output logic       o_timeout
);

    localparam logic [1:0] S_V1  = 2'b00;
    localparam logic [1:0] S_OP  = 2'b01;
    localparam logic [1:0] S_V2  = 2'b10;
    localparam logic [1:0] S_RES = 2'b11;

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    // Reject configurations where the idle limit or lockout length is meaningless.
    if (TIMEOUT_CYCLES < 2 || HOLDOFF_CYCLES < 1) begin : g_bad_param
        $error("calc_entry_fsm: TIMEOUT_CYCLES must be >= 2 and HOLDOFF_CYCLES >= 1");
    end

    logic [1:0]        r_state;
    logic [3:0]        r_v1;
    logic [3:0]        r_op;
    logic [3:0]        r_v2;
    logic              r_v2_seen;
    logic              r_calc_go;
    logic              r_err;
    logic              r_timeout;
    logic [IDLE_W-1:0] r_idle;

    logic [1:0]        w_state_nxt;
    logic [3:0]        w_v1_nxt;
    logic [3:0]        w_op_nxt;
    logic [3:0]        w_v2_nxt;
    logic              w_v2_seen_nxt;
    logic              w_calc_go_nxt;
    logic              w_err_nxt;
    logic              w_timeout_nxt;

    logic              w_accept;
    logic              w_expire;
    logic              w_is_digit;
    logic              w_is_op;
    logic              w_is_eq;
    logic              w_is_clr;

    assign w_is_digit = (i_key_code <= 4'h9);
    assign w_is_op    = (i_key_code >= 4'hA) && (i_key_code <= 4'hD);
    assign w_is_eq    = (i_key_code == 4'hE);
    assign w_is_clr   = (i_key_code == 4'hF);

`ifdef KEY_HOLDOFF_EN
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    logic [HOLD_W-1:0] r_hold;

    // Clear always gets through so the user can abort even while keys are locked out.
    assign w_accept = i_key_valid && ((r_hold == '0) || w_is_clr);

    // Lockout counter: reloaded by every accepted key, counts down to zero otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= HOLD_W'(HOLDOFF_CYCLES);
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
        end
    end
`else
    assign w_accept = i_key_valid;
`endif

    // A key arriving in the expiry cycle takes priority, so expiry requires no accept.
    assign w_expire = !w_accept && (r_state != S_V1) && (r_idle == IDLE_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_V1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: clear and idle expiry both fall back to operand-1 entry.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (w_is_clr) begin
                w_state_nxt = S_V1;
            end else begin
                case (r_state)
                    S_V1:    if (w_is_digit) w_state_nxt = S_OP;
                    S_OP:    if (w_is_op) w_state_nxt = S_V2;
                    S_V2:    if (w_is_eq && r_v2_seen) w_state_nxt = S_RES;
                    default: if (w_is_digit) w_state_nxt = S_OP;
                endcase
            end
        end else if (w_expire) begin
            w_state_nxt = S_V1;
        end
    end

    // Next values of the operand/operator registers and the event pulses.
    always_comb begin
        w_v1_nxt      = r_v1;
        w_op_nxt      = r_op;
        w_v2_nxt      = r_v2;
        w_v2_seen_nxt = r_v2_seen;
        w_calc_go_nxt = 1'b0;
        w_err_nxt     = 1'b0;
        w_timeout_nxt = 1'b0;
        if (w_accept) begin
            if (w_is_clr) begin
                w_v1_nxt      = 4'h0;
                w_op_nxt      = 4'h0;
                w_v2_nxt      = 4'h0;
                w_v2_seen_nxt = 1'b0;
            end else begin
                case (r_state)
                    S_V1: begin
                        if (w_is_digit) w_v1_nxt  = i_key_code;
                        else            w_err_nxt = 1'b1;
                    end
                    S_OP: begin
                        if (w_is_digit)   w_v1_nxt  = i_key_code;
                        else if (w_is_op) w_op_nxt  = i_key_code;
                        else              w_err_nxt = 1'b1;
                    end
                    S_V2: begin
                        if (w_is_digit) begin
                            w_v2_nxt      = i_key_code;
                            w_v2_seen_nxt = 1'b1;
                        end else if (w_is_op) begin
                            w_op_nxt = i_key_code;
                        end else if (r_v2_seen) begin
                            w_calc_go_nxt = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                    default: begin
                        // A digit after a result starts a fresh calculation.
                        if (w_is_digit) begin
                            w_v1_nxt      = i_key_code;
                            w_op_nxt      = 4'h0;
                            w_v2_nxt      = 4'h0;
                            w_v2_seen_nxt = 1'b0;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                endcase
            end
        end else if (w_expire) begin
            w_v1_nxt      = 4'h0;
            w_op_nxt      = 4'h0;
            w_v2_nxt      = 4'h0;
            w_v2_seen_nxt = 1'b0;
            w_timeout_nxt = 1'b1;
        end
    end

    // Data and pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1      <= 4'h0;
            r_op      <= 4'h0;
            r_v2      <= 4'h0;
            r_v2_seen <= 1'b0;
            r_calc_go <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_v1      <= w_v1_nxt;
            r_op      <= w_op_nxt;
            r_v2      <= w_v2_nxt;
            r_v2_seen <= w_v2_seen_nxt;
            r_calc_go <= w_calc_go_nxt;
            r_err     <= w_err_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Idle counter: runs only while waiting mid-entry, restarted by any accepted key.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idle <= '0;
        end else if (w_accept || (r_state == S_V1) || w_expire) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign o_state   = r_state;
    assign o_v1      = r_v1;
    assign o_op      = r_op;
    assign o_v2      = r_v2;
    assign o_calc_go = r_calc_go;
    assign o_err     = r_err;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb/tb_calc_entry_fsm.sv - scoreboard bench for calc_entry_fsm with random and directed key streams
module tb_calc_entry_fsm;

    localparam int TO = 20;
    localparam int HO = 3;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_key_valid = 1'b0;
    logic [3:0] i_key_code = 4'h0;
    logic [1:0] o_state;
    logic [3:0] o_v1, o_op, o_v2;
    logic       o_calc_go, o_err, o_timeout;

    calc_entry_fsm #(.TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_key_valid(i_key_valid), .i_key_code(i_key_code),
        .o_state(o_state), .o_v1(o_v1), .o_op(o_op), .o_v2(o_v2),
        .o_calc_go(o_calc_go), .o_err(o_err), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int v1; int op; int v2; int go; int er; int to;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: phase 0..3 = operand1, operator, operand2, result
    int m_phase = 0, m_v1 = 0, m_op = 0, m_v2 = 0, m_seen = 0, m_idle = 0, m_hold = 0;

    task automatic wipe();
        m_phase = 0; m_v1 = 0; m_op = 0; m_v2 = 0; m_seen = 0;
    endtask

    task automatic model_step(input bit rst, input bit kv, input int kc, output exp_t e);
        bit acc;
        e.go = 0; e.er = 0; e.to = 0;
        if (rst) begin
            wipe(); m_idle = 0; m_hold = 0;
        end else begin
`ifdef KEY_HOLDOFF_EN
            acc = kv && (m_hold == 0 || kc == 15);
            if (acc) m_hold = HO; else if (m_hold > 0) m_hold = m_hold - 1;
`else
            acc = kv;
`endif
            if (acc) begin
                m_idle = 0;
                if (kc == 15) wipe();
                else if (kc < 10) begin
                    if (m_phase == 2) begin m_v2 = kc; m_seen = 1; end
                    else begin
                        if (m_phase == 3) begin m_op = 0; m_v2 = 0; m_seen = 0; end
                        m_v1 = kc;
                        if (m_phase != 2) m_phase = 1;
                    end
                end else if (kc < 14) begin
                    if (m_phase == 1 || m_phase == 2) begin m_op = kc; m_phase = 2; end
                    else e.er = 1;
                end else begin
                    if (m_phase == 2 && m_seen == 1) begin m_phase = 3; e.go = 1; end
                    else e.er = 1;
                end
            end else if (m_phase == 0) begin
                m_idle = 0;
            end else if (m_idle == TO - 1) begin
                wipe(); m_idle = 0; e.to = 1;
            end else begin
                m_idle = m_idle + 1;
            end
        end
        e.st = m_phase; e.v1 = m_v1; e.op = m_op; e.v2 = m_v2;
    endtask

    task automatic drive(input bit rst, input bit kv, input int kc);
        exp_t e;
        @(negedge clk);
        i_rst = rst; i_key_valid = kv; i_key_code = 4'(kc);
        model_step(rst, kv, kc, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    task automatic key(input int kc);
        drive(1'b0, 1'b1, kc);
        idle(3);
    endtask

    task automatic chk(input string name, input int act, input int exp_v, input int cyc);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: one expected record per driven cycle, compared just after the edge
    int mon_cyc = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mon_cyc++;
                chk("state",   int'(o_state),   e.st, mon_cyc);
                chk("v1",      int'(o_v1),      e.v1, mon_cyc);
                chk("op",      int'(o_op),      e.op, mon_cyc);
                chk("v2",      int'(o_v2),      e.v2, mon_cyc);
                chk("calc_go", int'(o_calc_go), e.go, mon_cyc);
                chk("err",     int'(o_err),     e.er, mon_cyc);
                chk("timeout", int'(o_timeout), e.to, mon_cyc);
            end
        end
    end

    initial begin
        int r, kc;
        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 5);
        // basic calculation
        key(3); key(10); key(5); key(14); idle(2);
        // rejected keys in each entry phase
        key(15); key(10); key(1); key(14); key(11); key(14); idle(2);
        // idle expiry, then a key landing exactly on the expiry cycle
        key(15); key(2); key(11); idle(24);
        drive(1'b0, 1'b1, 2); idle(3); key(11); idle(16); key(7); idle(4);
        // clear after a result
        key(15); key(2); key(11); key(7); key(14); key(15);
        // reset mid operand-2 together with '='
        key(2); key(11); key(7); drive(1'b1, 1'b1, 14); idle(3);
        // new calculation from result, then '=' rejected
        key(3); key(10); key(5); key(14); key(9); key(14);
        // held strobe and clear during lockout
        key(15); drive(1'b0, 1'b1, 4); drive(1'b0, 1'b1, 4); drive(1'b0, 1'b1, 4);
        drive(1'b0, 1'b1, 15); idle(4);
        // randomized stream
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 59) == 0) idle(TO + $urandom_range(0, 3) - 2);
            kc = $urandom_range(0, 99);
            kc = (kc < 50) ? $urandom_range(0, 9) : (kc < 75) ? $urandom_range(10, 13) :
                 (kc < 96) ? 14 : 15;
            drive(r == 0, r < 45, kc);
        end
        idle(2);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0, mon_cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
